// File: rtl/spi_periph_pkg.sv
// Shared types and constants for the on-board SPI initiator.
package spi_periph_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    localparam logic DEV_EEPROM = 1'b0;
    localparam logic DEV_ADT    = 1'b1;
    localparam int unsigned MAX_LEN = 16;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: reloads on restart or after each tick, so every
// state entry starts a fresh CLK_DIV-cycle interval.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_periph_master.sv
// SPI mode-3 initiator for the EEPROM and ADT7301 on a shared bus, with
// optional CS hold so multi-field transactions stay under one select.
module spi_periph_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dev,
    input  logic [4:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_wdata,
    input  logic               cmd_hold,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_rdata,
    output logic               busy,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               e2_cs_n,
    output logic               adt_cs_n
);

    import spi_periph_pkg::*;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t             state;
    logic               dev;
    logic               hold;
    logic               pending;
    logic [4:0]         bit_cnt;
    logic [MAX_LEN-1:0] tx_sr;
    logic [MAX_LEN-1:0] rx_sr;
    logic [4:0]         len_c;
    logic [MAX_LEN-1:0] tx_aligned;
    logic               accept;
    logic               tick;

    assign accept = cmd_valid && cmd_ready;

    // Transmit word is left-aligned so the first bit is always the MSB.
    always_comb begin
        len_c      = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        tx_aligned = cmd_wdata << (LEN_MAX - len_c);
    end

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            spi_sclk  <= 1'b1;
            spi_mosi  <= 1'b0;
            e2_cs_n   <= 1'b1;
            adt_cs_n  <= 1'b1;
            dev       <= DEV_EEPROM;
            hold      <= 1'b0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        if (len_c == '0) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            dev       <= cmd_dev;
                            hold      <= cmd_hold;
                            bit_cnt   <= len_c;
                            tx_sr     <= tx_aligned;
                            rx_sr     <= '0;
                            state     <= SETUP;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            e2_cs_n   <= (cmd_dev != DEV_EEPROM);
                            adt_cs_n  <= (cmd_dev != DEV_ADT);
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state    <= LOW;
                        spi_sclk <= 1'b0;
                        spi_mosi <= tx_sr[MAX_LEN-1];
                        tx_sr    <= tx_sr << 1;
                        bit_cnt  <= bit_cnt - 5'd1;
                    end
                end
                LOW: begin
                    if (tick) begin
                        state    <= HIGH;
                        spi_sclk <= 1'b1;
                        rx_sr    <= {rx_sr[MAX_LEN-2:0], spi_miso};
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (bit_cnt != '0) begin
                            state    <= LOW;
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx_sr[MAX_LEN-1];
                            tx_sr    <= tx_sr << 1;
                            bit_cnt  <= bit_cnt - 5'd1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rx_sr;
                            if (hold) begin
                                state     <= HOLD;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state    <= GAP;
                                e2_cs_n  <= 1'b1;
                                adt_cs_n <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (len_c == '0) begin
                            state     <= GAP;
                            e2_cs_n   <= 1'b1;
                            adt_cs_n  <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (cmd_dev == dev) begin
                            // CS already set up: first bit goes out immediately.
                            hold     <= cmd_hold;
                            rx_sr    <= '0;
                            state    <= LOW;
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx_aligned[MAX_LEN-1];
                            tx_sr    <= tx_aligned << 1;
                            bit_cnt  <= len_c - 5'd1;
                        end else begin
                            dev      <= cmd_dev;
                            hold     <= cmd_hold;
                            bit_cnt  <= len_c;
                            tx_sr    <= tx_aligned;
                            rx_sr    <= '0;
                            pending  <= 1'b1;
                            state    <= GAP;
                            e2_cs_n  <= 1'b1;
                            adt_cs_n <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (pending) begin
                            pending  <= 1'b0;
                            state    <= SETUP;
                            e2_cs_n  <= (dev != DEV_EEPROM);
                            adt_cs_n <= (dev != DEV_ADT);
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_periph_master.sv
// Directed + randomized bench for spi_periph_master with an SPI slave model.
module tb_spi_periph_master;

    localparam int unsigned CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dev = 1'b0;
    logic [4:0]  cmd_len = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_hold = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        e2_cs_n;
    logic        adt_cs_n;

    always #5 clk = ~clk;

    spi_periph_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .cmd_hold  (cmd_hold),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .e2_cs_n   (e2_cs_n),
        .adt_cs_n  (adt_cs_n)
    );

    // Bus monitor: cumulative counters, read as deltas by the stimulus.
    int unsigned e2_low = 0, adt_low = 0, both_low = 0, rsp_cnt = 0;
    int unsigned e2_rise = 0, hi_run = 0, gap_before_adt = 0;
    logic        prev_e2 = 1'b1, prev_adt = 1'b1;

    always @(negedge clk) begin
        if (!e2_cs_n) e2_low++;
        if (!adt_cs_n) adt_low++;
        if (!e2_cs_n && !adt_cs_n) both_low++;
        if (rsp_valid) rsp_cnt++;
        if (e2_cs_n && !prev_e2) e2_rise++;
        if (!adt_cs_n && prev_adt) gap_before_adt = hi_run;
        if (e2_cs_n && adt_cs_n) hi_run++;
        else hi_run = 0;
        prev_e2  = e2_cs_n;
        prev_adt = adt_cs_n;
    end

    int unsigned sclk_rises = 0;
    logic [63:0] mosi_hist = '0;

    always @(posedge spi_sclk) begin
        sclk_rises++;
        mosi_hist = {mosi_hist[62:0], spi_mosi};
    end

    // Slave: presents slv_word MSB-first, changing MISO on each falling SCLK.
    int unsigned slv_falls = 0, slv_base = 0, slv_len = 0;
    logic [15:0] slv_word = '0;

    always @(negedge spi_sclk) begin
        int unsigned idx;
        idx = slv_falls - slv_base;
        if (idx < slv_len) spi_miso <= slv_word[slv_len-1-idx];
        else spi_miso <= 1'b0;
        slv_falls++;
    end

    int unsigned n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mask_len(input logic [15:0] w, input int unsigned len);
        int unsigned l;
        logic [31:0] m;
        l = (len > 16) ? 16 : len;
        m = (32'd1 << l) - 32'd1;
        return w & m[15:0];
    endfunction

    task automatic set_slave(input logic [15:0] w, input int unsigned len);
        slv_word = w;
        slv_len  = (len > 16) ? 16 : len;
        slv_base = slv_falls;
    endtask

    task automatic issue(input logic dev, input logic [4:0] len, input logic [15:0] wd, input logic hold);
        int unsigned n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dev   = dev;
        cmd_len   = len;
        cmd_wdata = wd;
        cmd_hold  = hold;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 2000), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp);
        int unsigned n;
        n = 0;
        while (!rsp_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
        chk(tag, 32'(rsp_rdata), 32'(exp));
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!(cmd_ready && !busy && e2_cs_n && adt_cs_n) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_time", 32'(n < 5000), 1);
        @(negedge clk);
        #1;
    endtask

    task automatic do_xfer(input string tag, input logic dev, input logic [4:0] len,
                           input logic [15:0] wd, input logic [15:0] sw);
        int unsigned l, r0, e0, a0, q0;
        l  = (len > 16) ? 16 : int'(len);
        r0 = sclk_rises; e0 = e2_low; a0 = adt_low; q0 = rsp_cnt;
        set_slave(sw, l);
        issue(dev, len, wd, 1'b0);
        wait_rsp(tag, mask_len(sw, l));
        wait_idle();
        chk({tag, "_edges"}, sclk_rises - r0, l);
        chk({tag, "_mosi"}, 32'(mask_len(mosi_hist[15:0], l)), 32'(mask_len(wd, l)));
        chk({tag, "_cs_cycles"}, dev ? adt_low - a0 : e2_low - e0, CLK_DIV * (1 + 2 * l));
        chk({tag, "_other_cs"}, dev ? e2_low - e0 : adt_low - a0, 0);
        chk({tag, "_rsp_count"}, rsp_cnt - q0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0, e0, a0, q0, er0, n;
        logic [15:0] w1, w2, wa, wb, cap;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sclk", 32'(spi_sclk), 1);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_cs", 32'({e2_cs_n, adt_cs_n}), 32'b11);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        #1;

        // ADT7301 16-bit read
        do_xfer("adt_read", 1'b1, 5'd16, 16'h0000, 16'h1F40);

        // EEPROM opcode/address/data under one CS
        r0 = sclk_rises; er0 = e2_rise; q0 = rsp_cnt; a0 = adt_low;
        set_slave(16'h0000, 8);
        issue(1'b0, 5'd8, 16'h0003, 1'b1);
        wait_rsp("e2_opcode", 16'h0000);
        chk("e2_hold_cs", 32'(e2_cs_n), 0);
        chk("e2_hold_ready", 32'(cmd_ready), 1);
        set_slave(16'h0000, 8);
        issue(1'b0, 5'd8, 16'h002A, 1'b1);
        wait_rsp("e2_addr", 16'h0000);
        set_slave(16'h00A5, 8);
        issue(1'b0, 5'd8, 16'h0000, 1'b0);
        wait_rsp("e2_data", 16'h00A5);
        wait_idle();
        chk("e2_cs_rises", e2_rise - er0, 1);
        chk("e2_rsp_count", rsp_cnt - q0, 3);
        chk("e2_edges", sclk_rises - r0, 24);
        chk("e2_mosi", 32'(mosi_hist[23:0]), 32'h03_2A_00);
        chk("e2_adt_quiet", adt_low - a0, 0);

        // Device switch out of HOLD
        wa = 16'($urandom); wb = 16'($urandom);
        er0 = e2_rise;
        set_slave(wa, 8);
        issue(1'b0, 5'd8, 16'($urandom), 1'b1);
        wait_rsp("sw_e2", mask_len(wa, 8));
        set_slave(wb, 16);
        issue(1'b1, 5'd16, 16'($urandom), 1'b0);
        wait_rsp("sw_adt", wb);
        wait_idle();
        chk("sw_gap_ge_div", 32'(gap_before_adt >= CLK_DIV), 1);
        chk("sw_e2_rise", e2_rise - er0, 1);

        // len=0 from IDLE
        r0 = sclk_rises; a0 = adt_low;
        issue(1'b1, 5'd0, 16'hFFFF, 1'b0);
        chk("len0_rsp_valid", 32'(rsp_valid), 1);
        chk("len0_rdata", 32'(rsp_rdata), 0);
        @(negedge clk);
        chk("len0_single_pulse", 32'(rsp_valid), 0);
        #1;
        chk("len0_no_edges", sclk_rises - r0, 0);
        chk("len0_no_cs", adt_low - a0, 0);

        // Length clamp and single bit
        do_xfer("len20", 1'b1, 5'd20, 16'($urandom), 16'($urandom));
        do_xfer("len1", 1'b0, 5'd1, 16'($urandom), 16'h0001);

        // HOLD released by a zero-length command
        er0 = e2_rise;
        set_slave(16'h00C3, 8);
        issue(1'b0, 5'd8, 16'h0055, 1'b1);
        wait_rsp("rel_data", 16'h00C3);
        issue(1'b0, 5'd0, 16'h0000, 1'b0);
        wait_rsp("rel_zero", 16'h0000);
        wait_idle();
        chk("rel_cs_rise", e2_rise - er0, 1);

        // Randomized single transfers
        for (int i = 0; i < 6; i++) begin
            do_xfer($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                    5'($urandom_range(1, 16)), 16'($urandom), 16'($urandom));
        end

        // cmd_valid held through a transfer
        w1 = 16'($urandom); w2 = 16'($urandom);
        wa = 16'($urandom); wb = 16'($urandom);
        r0 = sclk_rises; q0 = rsp_cnt; e0 = e2_low; a0 = adt_low;
        cap = 16'hDEAD;
        set_slave(wa, 8);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dev = 1'b1; cmd_len = 5'd8; cmd_wdata = w1; cmd_hold = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_dev = 1'b0; cmd_len = 5'd4; cmd_wdata = w2;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            if (rsp_valid) cap = rsp_rdata;
            @(negedge clk);
            n++;
        end
        chk("hs_ready_low_cycles", n, CLK_DIV * (1 + 2 * 8) + CLK_DIV);
        chk("hs_first_rdata", 32'(cap), 32'(mask_len(wa, 8)));
        set_slave(wb, 4);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("hs_second", mask_len(wb, 4));
        wait_idle();
        chk("hs_rsp_count", rsp_cnt - q0, 2);
        chk("hs_edges", sclk_rises - r0, 12);
        chk("hs_mosi", 32'(mosi_hist[11:0]), 32'({w1[7:0], w2[3:0]}));
        chk("hs_adt_cycles", adt_low - a0, CLK_DIV * 17);
        chk("hs_e2_cycles", e2_low - e0, CLK_DIV * 9);

        // Reset in the middle of an ADT read
        set_slave(16'($urandom), 16);
        r0 = sclk_rises;
        issue(1'b1, 5'd16, 16'($urandom), 1'b0);
        n = 0;
        while (sclk_rises - r0 < 5 && n < 2000) begin @(negedge clk); n++; end
        q0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sclk", 32'(spi_sclk), 1);
        chk("mid_rst_cs", 32'({e2_cs_n, adt_cs_n}), 32'b11);
        chk("mid_rst_rsp", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        repeat (200) @(negedge clk);
        #1;
        chk("mid_rst_no_rsp", rsp_cnt - q0, 0);
        chk("never_both_cs_low", both_low, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
